itch_msg_arbiter: RTL and testbench
===================================

ITCH_MSG_ARBITER -- requirements
Module: itch_msg_arbiter

Interface
REQ-001 SHALL have parameter DROP_CNT_W, default 16, width of the dropped-message counter.
REQ-002 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port add_valid  input  1  add decoder one-cycle done pulse; fields below valid same cycle.
REQ-005 SHALL have ports add_order_ref (in, 64), add_side (in, 1), add_shares (in, 32), add_price (in, 32), add_stock_symbol (in, 64).
REQ-006 SHALL have port cancel_valid  input  1  cancel decoder done pulse; cancel_order_ref (in, 64), cancel_shares (in, 32).
REQ-007 SHALL have port delete_valid  input  1  delete decoder done pulse; delete_order_ref (in, 64).
REQ-008 SHALL have port replace_valid  input  1  replace decoder done pulse; replace_old_ref (in, 64), replace_new_ref (in, 64), replace_shares (in, 32), replace_price (in, 32).
REQ-009 SHALL have port out_valid  output  1  unified message available.
REQ-010 SHALL have port out_ready  input  1  downstream accepts; transfer when out_valid and out_ready.
REQ-011 SHALL have port out_type  output  2  0=add, 1=cancel, 2=delete, 3=replace.
REQ-012 SHALL have ports out_order_ref (64), out_new_ref (64), out_shares (32), out_price (32), out_side (1), out_symbol (64), all outputs.
REQ-013 SHALL have port drop_count  output  DROP_CNT_W  messages lost to slot overflow.
REQ-014 SHALL have port overflow  output  1  sticky flag, set on first drop.

Function
REQ-015 SHALL hold one capture slot per source (pending bit + fields); a valid pulse loads that source's slot at the next edge.
REQ-016 Field mapping SHALL be: cancel/delete/replace old ref -> out_order_ref; replace new ref -> out_new_ref; add/cancel/replace shares -> out_shares; unused output fields SHALL be driven zero.
REQ-017 Output register SHALL load when any slot is pending and (out_valid==0 or out_ready==1); the granted slot's pending bit clears on the same edge.
REQ-018 out_valid and all out_* fields SHALL stay stable while out_valid==1 and out_ready==0.
REQ-019 Latency SHALL be 2 cycles: valid pulse in cycle N, idle arbiter -> out_valid high in cycle N+2.
REQ-020 Full-throughput: with out_ready held 1, one message SHALL transfer per cycle while any slot is pending.
REQ-021 Valid on a source whose slot is granted the same cycle SHALL reload the slot (no drop).
REQ-022 Valid on a source whose slot is pending and not granted that cycle SHALL be discarded, old contents kept, drop_count incremented, overflow set.
REQ-023 drop_count SHALL saturate at all-ones; overflow SHALL clear only on reset.
REQ-024 Simultaneous valids on multiple sources SHALL all be captured; grant order per REQ-029.

Reset
REQ-025 On rst low, asynchronously: all pending bits 0, out_valid 0, all out_* fields 0, drop_count 0, overflow 0, round-robin pointer 3.
REQ-026 Reset asserted mid-operation SHALL discard all pending and held messages; no transfer occurs in the cycle rst deasserts.
REQ-027 Inputs SHALL be ignored while rst is low.

Configuration
REQ-028 Macro ITCH_ARB_RR_EN SHALL select the arbitration policy.
REQ-029 Defined: round-robin; search starts at (last granted index + 1) mod 4, pointer updates only on grant. Undefined: fixed priority add > cancel > delete > replace, pointer unused.

Verification
REQ-030 Single add pulse (ref 0x1122334455667788, shares 100, price 0x0001E240, side 1), out_ready=1 -> out_valid in cycle N+2, out_type 0, fields match, one cycle only.
REQ-031 add and cancel pulsed same cycle, out_ready=1 -> two consecutive transfers, type 0 then 1 (both builds).
REQ-032 out_ready=0, delete pulsed twice 2 cycles apart -> first held stable, second dropped, drop_count=1, overflow=1.
REQ-033 RR build, all four slots kept pending by re-pulsing each grant cycle -> grant order 0,1,2,3,0; fixed build -> type 0 every cycle.
REQ-034 Force drop_count to all-ones via 65535+ drops -> stays 0xFFFF.
REQ-035 Assert rst while out_valid=1 and three slots pending -> out_valid 0 immediately, no output after release until new pulse.

Source files
------------

// File: rtl/itch_msg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : itch_msg_arbiter
//  Purpose  : Merges add/cancel/delete/replace decoder pulses into one
//             valid/ready message stream. Each source has a one-deep capture
//             slot. Messages that arrive at a full slot are dropped and counted.
//  Config   : define ITCH_ARB_RR_EN for round-robin arbitration.
//             Without it, arbitration is fixed priority add > cancel > delete > replace.
//  Revision : 1.0 - initial release
// ============================================================================
module itch_msg_arbiter #(
   parameter int DROP_CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  add_valid,
   input  logic [63:0]           add_order_ref,
   input  logic                  add_side,
   input  logic [31:0]           add_shares,
   input  logic [31:0]           add_price,
   input  logic [63:0]           add_stock_symbol,
   input  logic                  cancel_valid,
   input  logic [63:0]           cancel_order_ref,
   input  logic [31:0]           cancel_shares,
   input  logic                  delete_valid,
   input  logic [63:0]           delete_order_ref,
   input  logic                  replace_valid,
   input  logic [63:0]           replace_old_ref,
   input  logic [63:0]           replace_new_ref,
   input  logic [31:0]           replace_shares,
   input  logic [31:0]           replace_price,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [1:0]            out_type,
   output logic [63:0]           out_order_ref,
   output logic [63:0]           out_new_ref,
   output logic [31:0]           out_shares,
   output logic [31:0]           out_price,
   output logic                  out_side,
   output logic [63:0]           out_symbol,
   output logic [DROP_CNT_W-1:0] drop_count,
   output logic                  overflow
);

   localparam int c_NUM_SRC = 4;

   // Slots hold the message already mapped to the unified layout, with unused fields zero.
   typedef struct packed {
      logic [63:0] order_ref;
      logic [63:0] new_ref;
      logic [31:0] shares;
      logic [31:0] price;
      logic        side;
      logic [63:0] symbol;
   } msg_rec_t;

   logic [3:0]          w_in_valid;
   msg_rec_t            w_in_rec [c_NUM_SRC];
   logic [3:0]          r_pend;
   msg_rec_t            r_slot [c_NUM_SRC];
   logic                w_load;
   logic [1:0]          w_grant_idx;
   logic [3:0]          w_grant_oh;
   logic [3:0]          w_accept;
   logic [3:0]          w_drop;
   logic [2:0]          w_drop_num;
   logic [DROP_CNT_W:0] w_drop_sum;

   logic                  r_out_valid;
   logic [1:0]            r_out_type;
   msg_rec_t              r_out_rec;
   logic [DROP_CNT_W-1:0] r_drop_count;
   logic                  r_overflow;

   assign w_in_valid = {replace_valid, delete_valid, cancel_valid, add_valid};

   always_comb begin
      for (int i = 0; i < c_NUM_SRC; i++) begin
         w_in_rec[i] = '0;
      end
      w_in_rec[0].order_ref = add_order_ref;
      w_in_rec[0].shares    = add_shares;
      w_in_rec[0].price     = add_price;
      w_in_rec[0].side      = add_side;
      w_in_rec[0].symbol    = add_stock_symbol;
      w_in_rec[1].order_ref = cancel_order_ref;
      w_in_rec[1].shares    = cancel_shares;
      w_in_rec[2].order_ref = delete_order_ref;
      w_in_rec[3].order_ref = replace_old_ref;
      w_in_rec[3].new_ref   = replace_new_ref;
      w_in_rec[3].shares    = replace_shares;
      w_in_rec[3].price     = replace_price;
   end

   assign w_load = (|r_pend) && (!r_out_valid || out_ready);

`ifdef ITCH_ARB_RR_EN
   logic [1:0] r_rr_ptr;
   logic       w_found;

   // Search begins one past the last granted source and wraps modulo 4.
   always_comb begin
      w_grant_idx = r_rr_ptr + 2'd1;
      w_found     = 1'b0;
      for (int k = 1; k <= c_NUM_SRC; k++) begin
         if (!w_found && r_pend[r_rr_ptr + 2'(k)]) begin
            w_grant_idx = r_rr_ptr + 2'(k);
            w_found     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rr_ptr <= 2'd3;
      end else if (w_load) begin
         r_rr_ptr <= w_grant_idx;
      end
   end
`else
   always_comb begin
      w_grant_idx = 2'd0;
      for (int k = c_NUM_SRC - 1; k >= 0; k--) begin
         if (r_pend[k]) begin
            w_grant_idx = 2'(k);
         end
      end
   end
`endif

   assign w_grant_oh = w_load ? (4'b0001 << w_grant_idx) : 4'b0000;

   // A slot being emptied this edge may take a fresh message. Otherwise a busy slot drops it.
   assign w_accept   = w_in_valid & (~r_pend | w_grant_oh);
   assign w_drop     = w_in_valid & r_pend & ~w_grant_oh;
   assign w_drop_num = {2'b00, w_drop[0]} + {2'b00, w_drop[1]}
                     + {2'b00, w_drop[2]} + {2'b00, w_drop[3]};
   assign w_drop_sum = {1'b0, r_drop_count} + (DROP_CNT_W + 1)'(w_drop_num);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend <= 4'b0000;
         for (int i = 0; i < c_NUM_SRC; i++) begin
            r_slot[i] <= '0;
         end
      end else begin
         for (int i = 0; i < c_NUM_SRC; i++) begin
            if (w_accept[i]) begin
               r_pend[i] <= 1'b1;
               r_slot[i] <= w_in_rec[i];
            end else if (w_grant_oh[i]) begin
               r_pend[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_valid <= 1'b0;
         r_out_type  <= 2'd0;
         r_out_rec   <= '0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_type  <= w_grant_idx;
         r_out_rec   <= r_slot[w_grant_idx];
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_drop_count <= '0;
         r_overflow   <= 1'b0;
      end else if (|w_drop) begin
         r_overflow <= 1'b1;
         if (w_drop_sum[DROP_CNT_W]) begin
            r_drop_count <= '1;
         end else begin
            r_drop_count <= w_drop_sum[DROP_CNT_W-1:0];
         end
      end
   end

   assign out_valid     = r_out_valid;
   assign out_type      = r_out_type;
   assign out_order_ref = r_out_rec.order_ref;
   assign out_new_ref   = r_out_rec.new_ref;
   assign out_shares    = r_out_rec.shares;
   assign out_price     = r_out_rec.price;
   assign out_side      = r_out_rec.side;
   assign out_symbol    = r_out_rec.symbol;
   assign drop_count    = r_drop_count;
   assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_itch_msg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_itch_msg_arbiter
//  Purpose  : Self-checking bench for itch_msg_arbiter. It uses a vector table,
//             directed corner cases, and random traffic against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_itch_msg_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        add_valid, add_side, cancel_valid, delete_valid, replace_valid, out_ready;
   logic [63:0] add_order_ref, add_stock_symbol, cancel_order_ref, delete_order_ref;
   logic [63:0] replace_old_ref, replace_new_ref;
   logic [31:0] add_shares, add_price, cancel_shares, replace_shares, replace_price;
   logic        out_valid, out_side, overflow;
   logic [1:0]  out_type;
   logic [63:0] out_order_ref, out_new_ref, out_symbol;
   logic [31:0] out_shares, out_price;
   logic [15:0] drop_count;

   itch_msg_arbiter #(.DROP_CNT_W(16)) u_dut (
      .clk(clk), .rst(rst),
      .add_valid(add_valid), .add_order_ref(add_order_ref), .add_side(add_side),
      .add_shares(add_shares), .add_price(add_price), .add_stock_symbol(add_stock_symbol),
      .cancel_valid(cancel_valid), .cancel_order_ref(cancel_order_ref), .cancel_shares(cancel_shares),
      .delete_valid(delete_valid), .delete_order_ref(delete_order_ref),
      .replace_valid(replace_valid), .replace_old_ref(replace_old_ref),
      .replace_new_ref(replace_new_ref), .replace_shares(replace_shares), .replace_price(replace_price),
      .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
      .out_order_ref(out_order_ref), .out_new_ref(out_new_ref), .out_shares(out_shares),
      .out_price(out_price), .out_side(out_side), .out_symbol(out_symbol),
      .drop_count(drop_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] oref;
      logic [63:0] nref;
      logic [31:0] sh;
      logic [31:0] pr;
      logic        sd;
      logic [63:0] sym;
   } rec_t;

   typedef struct {
      logic [3:0]  vld;
      logic [63:0] ref_v;
      logic        rdy;
      logic        e_v;
      logic [1:0]  e_t;
      logic [63:0] e_ref;
      logic [15:0] e_drop;
      logic        e_ovf;
   } vec_t;

   int n_chk = 0;
   int n_err = 0;

   // Reference model state, one message slot per source
   logic        m_pend [4];
   rec_t        m_rec  [4];
   logic        m_ov;
   logic [1:0]  m_ot;
   rec_t        m_orec;
   logic [15:0] m_drop;
   logic        m_ovf;
   int          m_last;

   task automatic chk(input string nm, input logic [259:0] act, input logic [259:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic rec_t mk_rec(input int s);
      rec_t r = '0;
      case (s)
         0: begin r.oref = add_order_ref; r.sh = add_shares; r.pr = add_price;
                  r.sd = add_side; r.sym = add_stock_symbol; end
         1: begin r.oref = cancel_order_ref; r.sh = cancel_shares; end
         2: r.oref = delete_order_ref;
         default: begin r.oref = replace_old_ref; r.nref = replace_new_ref;
                  r.sh = replace_shares; r.pr = replace_price; end
      endcase
      return r;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 4; s++) begin m_pend[s] = 1'b0; m_rec[s] = '0; end
      m_ov = 1'b0; m_ot = 2'd0; m_orec = '0; m_drop = 16'd0; m_ovf = 1'b0; m_last = 3;
   endtask

   task automatic model_step();
      logic [3:0] vin;
      logic       old_p [4];
      logic       any_p;
      int         g;
      vin   = {replace_valid, delete_valid, cancel_valid, add_valid};
      any_p = 1'b0;
      g     = -1;
      for (int s = 0; s < 4; s++) begin old_p[s] = m_pend[s]; any_p |= m_pend[s]; end
      if (any_p && (!m_ov || out_ready)) begin
`ifdef ITCH_ARB_RR_EN
         for (int k = 1; k <= 4; k++)
            if (g < 0 && old_p[(m_last + k) % 4]) g = (m_last + k) % 4;
`else
         for (int k = 0; k < 4; k++)
            if (g < 0 && old_p[k]) g = k;
`endif
      end
      if (g >= 0) begin
         m_ov = 1'b1; m_ot = 2'(g); m_orec = m_rec[g]; m_pend[g] = 1'b0; m_last = g;
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      for (int s = 0; s < 4; s++) begin
         if (vin[s]) begin
            if (old_p[s] && s != g) begin
               if (m_drop != 16'hFFFF) m_drop++;
               m_ovf = 1'b1;
            end else begin
               m_pend[s] = 1'b1;
               m_rec[s]  = mk_rec(s);
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!rst) model_reset(); else model_step();
      #1;
   endtask

   task automatic clr_in();
      add_valid = 0; cancel_valid = 0; delete_valid = 0; replace_valid = 0;
      add_order_ref = 64'd0; add_side = 1'b1; add_shares = 32'd100; add_price = 32'h0001E240;
      add_stock_symbol = 64'h4141504C20202020;
      cancel_order_ref = 64'd0; cancel_shares = 32'd7; delete_order_ref = 64'd0;
      replace_old_ref = 64'd0; replace_new_ref = 64'h55; replace_shares = 32'd9; replace_price = 32'd11;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      model_reset();
      chk("rst_valid", out_valid, 0);
      chk("rst_fields", {out_type, out_order_ref, out_new_ref, out_shares, out_price, out_side, out_symbol}, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_ovf", overflow, 0);
      repeat (2) @(posedge clk);
      #1;
      clr_in();
      rst = 1'b1;
   endtask

   task automatic chk_model(input string nm);
      chk({nm, "_valid"}, out_valid, m_ov);
      chk({nm, "_drop"}, drop_count, m_drop);
      chk({nm, "_ovf"}, overflow, m_ovf);
      if (m_ov) begin
         chk({nm, "_type"}, out_type, m_ot);
         chk({nm, "_rec"}, {out_order_ref, out_new_ref, out_shares, out_price, out_side, out_symbol}, m_orec);
      end
   endtask

   vec_t tbl [14];
   localparam logic [63:0] c_REF_A = 64'h1122334455667788;

   initial begin
      // vld = {replace, delete, cancel, add}
      tbl[0]  = '{4'b0011, c_REF_A, 1'b1, 1'b0, 2'd0, 64'd0,    16'd0, 1'b0};
      tbl[1]  = '{4'b0000, 64'd0,   1'b1, 1'b1, 2'd0, c_REF_A,  16'd0, 1'b0};
      tbl[2]  = '{4'b0000, 64'd0,   1'b1, 1'b1, 2'd1, c_REF_A,  16'd0, 1'b0};
      tbl[3]  = '{4'b0000, 64'd0,   1'b1, 1'b0, 2'd0, 64'd0,    16'd0, 1'b0};
      tbl[4]  = '{4'b0001, 64'hB0,  1'b1, 1'b0, 2'd0, 64'd0,    16'd0, 1'b0};
      tbl[5]  = '{4'b0000, 64'd0,   1'b1, 1'b1, 2'd0, 64'hB0,   16'd0, 1'b0};
      tbl[6]  = '{4'b0000, 64'd0,   1'b1, 1'b0, 2'd0, 64'd0,    16'd0, 1'b0};
      tbl[7]  = '{4'b0100, 64'hC0,  1'b0, 1'b0, 2'd0, 64'd0,    16'd0, 1'b0};
      tbl[8]  = '{4'b0000, 64'd0,   1'b0, 1'b1, 2'd2, 64'hC0,   16'd0, 1'b0};
      tbl[9]  = '{4'b0100, 64'hD0,  1'b0, 1'b1, 2'd2, 64'hC0,   16'd0, 1'b0};
      tbl[10] = '{4'b0000, 64'd0,   1'b0, 1'b1, 2'd2, 64'hC0,   16'd0, 1'b0};
      tbl[11] = '{4'b0100, 64'hE0,  1'b0, 1'b1, 2'd2, 64'hC0,   16'd1, 1'b1};
      tbl[12] = '{4'b0000, 64'd0,   1'b1, 1'b1, 2'd2, 64'hD0,   16'd1, 1'b1};
      tbl[13] = '{4'b0000, 64'd0,   1'b1, 1'b0, 2'd0, 64'd0,    16'd1, 1'b1};

      clr_in();
      out_ready = 1'b1;
      do_reset();

      for (int i = 0; i < 14; i++) begin
         clr_in();
         {replace_valid, delete_valid, cancel_valid, add_valid} = tbl[i].vld;
         add_order_ref = tbl[i].ref_v; cancel_order_ref = tbl[i].ref_v;
         delete_order_ref = tbl[i].ref_v; replace_old_ref = tbl[i].ref_v;
         out_ready = tbl[i].rdy;
         cycle();
         chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_v);
         chk($sformatf("tbl%0d_drop", i), drop_count, tbl[i].e_drop);
         chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].e_ovf);
         if (tbl[i].e_v) begin
            chk($sformatf("tbl%0d_type", i), out_type, tbl[i].e_t);
            chk($sformatf("tbl%0d_ref", i), out_order_ref, tbl[i].e_ref);
            if (tbl[i].e_t == 2'd0)
               chk($sformatf("tbl%0d_addflds", i), {out_shares, out_price, out_side, out_new_ref},
                   {32'd100, 32'h0001E240, 1'b1, 64'd0});
         end
      end

      // Keep all four slots busy and refill each one as it is granted.
      clr_in(); out_ready = 1'b1;
      do_reset();
      {replace_valid, delete_valid, cancel_valid, add_valid} = 4'b1111;
      cycle();
      chk("arb_prime_valid", out_valid, 0);
      for (int k = 0; k < 5; k++) begin
         int e;
`ifdef ITCH_ARB_RR_EN
         e = k % 4;
`else
         e = 0;
`endif
         clr_in();
         case (e)
            0: add_valid = 1'b1;
            1: cancel_valid = 1'b1;
            2: delete_valid = 1'b1;
            default: replace_valid = 1'b1;
         endcase
         cycle();
         chk($sformatf("arb%0d_valid", k), out_valid, 1);
         chk($sformatf("arb%0d_type", k), out_type, 2'(e));
         chk($sformatf("arb%0d_drop", k), drop_count, 0);
      end

      // With the output stalled, every pulse on a full slot is dropped until the counter saturates.
      clr_in(); out_ready = 1'b0;
      do_reset();
      for (int n = 1; n <= 16386; n++) begin
         {replace_valid, delete_valid, cancel_valid, add_valid} = 4'b1111;
         cycle();
         if (n == 100) chk("drop_cnt_395", drop_count, 16'd395);
      end
      chk("drop_sat", drop_count, 16'hFFFF);
      chk("drop_ovf", overflow, 1);
      repeat (10) cycle();
      chk("drop_sat_hold", drop_count, 16'hFFFF);
      chk("drop_hold_valid", out_valid, 1);

      // Assert reset asynchronously while one message is held and three slots are pending.
      clr_in(); out_ready = 1'b0;
      do_reset();
      add_valid = 1'b1; add_order_ref = 64'hAAAA;
      cycle();
      clr_in();
      cycle();
      chk("ar_held_valid", out_valid, 1);
      cancel_valid = 1'b1; delete_valid = 1'b1; replace_valid = 1'b1;
      cycle();
      clr_in();
      chk("ar_pre_valid", out_valid, 1);
      #2;
      rst = 1'b0;
      model_reset();
      add_valid = 1'b1; cancel_valid = 1'b1;
      #1;
      chk("ar_async_valid", out_valid, 0);
      chk("ar_async_ref", out_order_ref, 0);
      cycle();
      cycle();
      clr_in();
      out_ready = 1'b1;
      rst = 1'b1;
      for (int q = 0; q < 5; q++) begin
         cycle();
         chk($sformatf("ar_quiet%0d", q), out_valid, 0);
      end
      add_valid = 1'b1; add_order_ref = 64'hBEEF;
      cycle();
      clr_in();
      chk("ar_new_n1", out_valid, 0);
      cycle();
      chk("ar_new_n2_valid", out_valid, 1);
      chk("ar_new_n2_ref", out_order_ref, 64'hBEEF);

      // Random traffic compared with the reference model
      clr_in(); out_ready = 1'b1;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         add_valid = ($urandom_range(0, 2) == 0);
         cancel_valid = ($urandom_range(0, 2) == 0);
         delete_valid = ($urandom_range(0, 2) == 0);
         replace_valid = ($urandom_range(0, 2) == 0);
         add_order_ref = {$urandom, $urandom}; add_side = 1'($urandom);
         add_shares = $urandom; add_price = $urandom; add_stock_symbol = {$urandom, $urandom};
         cancel_order_ref = {$urandom, $urandom}; cancel_shares = $urandom;
         delete_order_ref = {$urandom, $urandom};
         replace_old_ref = {$urandom, $urandom}; replace_new_ref = {$urandom, $urandom};
         replace_shares = $urandom; replace_price = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
         chk_model("rnd");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
